// File: rtl/axi_pkg.sv
// AXI channel types shared by the CPU array, the arbiter and the memory bridge,
// plus the arbiter FSM encodings and the round-robin pick helper.
package axi_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    // Upper bound on managers handled by rr_pick; RR_IDX_W must cover RR_MAX_N-1.
    localparam int RR_MAX_N = 32;
    localparam int RR_IDX_W = 5;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } axi_r_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } arb_wstate_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } arb_rstate_e;

    // First set bit of valid_vec at or above ptr, wrapping modulo n.
    // Returns ptr when nothing is valid; callers gate with |valid_vec.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX_N-1:0] valid_vec,
        input logic [RR_IDX_W-1:0] ptr,
        input int                  n
    );
        logic [RR_IDX_W-1:0] winner;
        logic                found;
        logic [RR_IDX_W:0]   idx;
        winner = ptr;
        found  = 1'b0;
        for (int i = 0; i < RR_MAX_N; i++) begin
            if (i < n) begin
                idx = {1'b0, ptr} + (RR_IDX_W+1)'(i);
                if (idx >= (RR_IDX_W+1)'(n)) begin
                    idx = idx - (RR_IDX_W+1)'(n);
                end
                if (!found && valid_vec[idx[RR_IDX_W-1:0]]) begin
                    winner = idx[RR_IDX_W-1:0];
                    found  = 1'b1;
                end
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/axi_rr_arbiter_if.sv
// Bundle of the N upstream AXI manager ports and the single downstream port.
// slave: arbiter view; master: the CPU array + memory bridge view.
interface axi_rr_arbiter_if #(
    parameter int N_MANAGERS = 4
);
    import axi_pkg::*;

    axi_aw_t i_axi_s_aw      [N_MANAGERS];
    logic    i_axi_s_awvalid [N_MANAGERS];
    logic    o_axi_s_awready [N_MANAGERS];
    axi_w_t  i_axi_s_w       [N_MANAGERS];
    logic    i_axi_s_wvalid  [N_MANAGERS];
    logic    o_axi_s_wready  [N_MANAGERS];
    axi_b_t  o_axi_s_b       [N_MANAGERS];
    logic    o_axi_s_bvalid  [N_MANAGERS];
    logic    i_axi_s_bready  [N_MANAGERS];
    axi_ar_t i_axi_s_ar      [N_MANAGERS];
    logic    i_axi_s_arvalid [N_MANAGERS];
    logic    o_axi_s_arready [N_MANAGERS];
    axi_r_t  o_axi_s_r       [N_MANAGERS];
    logic    o_axi_s_rvalid  [N_MANAGERS];
    logic    i_axi_s_rready  [N_MANAGERS];

    axi_aw_t o_axi_m_aw;
    logic    o_axi_m_awvalid;
    logic    i_axi_m_awready;
    axi_w_t  o_axi_m_w;
    logic    o_axi_m_wvalid;
    logic    i_axi_m_wready;
    axi_b_t  i_axi_m_b;
    logic    i_axi_m_bvalid;
    logic    o_axi_m_bready;
    axi_ar_t o_axi_m_ar;
    logic    o_axi_m_arvalid;
    logic    i_axi_m_arready;
    axi_r_t  i_axi_m_r;
    logic    i_axi_m_rvalid;
    logic    o_axi_m_rready;

    modport slave (
        input  i_axi_s_aw, i_axi_s_awvalid, i_axi_s_w, i_axi_s_wvalid, i_axi_s_bready,
        input  i_axi_s_ar, i_axi_s_arvalid, i_axi_s_rready,
        output o_axi_s_awready, o_axi_s_wready, o_axi_s_b, o_axi_s_bvalid,
        output o_axi_s_arready, o_axi_s_r, o_axi_s_rvalid,
        output o_axi_m_aw, o_axi_m_awvalid, o_axi_m_w, o_axi_m_wvalid, o_axi_m_bready,
        output o_axi_m_ar, o_axi_m_arvalid, o_axi_m_rready,
        input  i_axi_m_awready, i_axi_m_wready, i_axi_m_b, i_axi_m_bvalid,
        input  i_axi_m_arready, i_axi_m_r, i_axi_m_rvalid
    );

    modport master (
        output i_axi_s_aw, i_axi_s_awvalid, i_axi_s_w, i_axi_s_wvalid, i_axi_s_bready,
        output i_axi_s_ar, i_axi_s_arvalid, i_axi_s_rready,
        input  o_axi_s_awready, o_axi_s_wready, o_axi_s_b, o_axi_s_bvalid,
        input  o_axi_s_arready, o_axi_s_r, o_axi_s_rvalid,
        input  o_axi_m_aw, o_axi_m_awvalid, o_axi_m_w, o_axi_m_wvalid, o_axi_m_bready,
        input  o_axi_m_ar, o_axi_m_arvalid, o_axi_m_rready,
        output i_axi_m_awready, i_axi_m_wready, i_axi_m_b, i_axi_m_bvalid,
        output i_axi_m_arready, i_axi_m_r, i_axi_m_rvalid
    );

endinterface

// File: rtl/axi_rr_arbiter_rr_pick_next.sv
// Combinational round-robin winner for one arbitration path (N <= RR_MAX_N).
module rr_pick_next
    import axi_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             any_valid,
    output logic [IDX_W-1:0] winner
);

    logic [RR_MAX_N-1:0] valid_ext;
    logic [RR_IDX_W-1:0] pick;

    assign valid_ext = RR_MAX_N'(valid);
    assign pick      = rr_pick(valid_ext, RR_IDX_W'(ptr), N);
    assign winner    = IDX_W'(pick);
    assign any_valid = |valid;

endmodule

// File: rtl/axi_rr_arbiter.sv
// Round-robin N:1 AXI arbiter with independent write and read paths.
// Optional AXI_ARB_ID_CHECK_EN adds a sticky response-ID mismatch flag (o_id_err).
module axi_rr_arbiter
    import axi_pkg::*;
#(
    parameter int N_MANAGERS = 4,
    parameter int GRANT_W    = (N_MANAGERS > 1) ? $clog2(N_MANAGERS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    axi_rr_arbiter_if.slave  bus
`ifdef AXI_ARB_ID_CHECK_EN
    ,
    output logic             o_id_err
`endif
);

    function automatic logic [GRANT_W-1:0] ptr_inc(input logic [GRANT_W-1:0] g);
        return (g == GRANT_W'(N_MANAGERS - 1)) ? '0 : g + 1'b1;
    endfunction

    logic [N_MANAGERS-1:0] awvalid_vec;
    logic [N_MANAGERS-1:0] arvalid_vec;

    generate
        for (genvar gi = 0; gi < N_MANAGERS; gi++) begin : g_req
            assign awvalid_vec[gi] = bus.i_axi_s_awvalid[gi];
            assign arvalid_vec[gi] = bus.i_axi_s_arvalid[gi];
        end
    endgenerate

    // ---------------- write path ----------------
    arb_wstate_e        wstate_reg, wstate_next;
    logic [GRANT_W-1:0] wgrant_reg, wgrant_next;
    logic [GRANT_W-1:0] wptr_reg, wptr_next;
    logic [GRANT_W-1:0] wwin;
    logic               wany;

    axi_aw_t m_aw;
    logic    m_awvalid;
    axi_w_t  m_w;
    logic    m_wvalid;
    logic    m_bready;

    rr_pick_next #(.N(N_MANAGERS), .IDX_W(GRANT_W)) u_wpick (
        .valid     (awvalid_vec),
        .ptr       (wptr_reg),
        .any_valid (wany),
        .winner    (wwin)
    );

    always_comb begin
        wstate_next = wstate_reg;
        wgrant_next = wgrant_reg;
        wptr_next   = wptr_reg;
        m_aw        = '0;
        m_awvalid   = 1'b0;
        m_w         = '0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        case (wstate_reg)
            W_IDLE: begin
                if (wany) begin
                    wgrant_next = wwin;
                    wstate_next = W_AW;
                end
            end
            W_AW: begin
                m_aw      = bus.i_axi_s_aw[wgrant_reg];
                m_awvalid = bus.i_axi_s_awvalid[wgrant_reg];
                if (m_awvalid && bus.i_axi_m_awready) begin
                    wstate_next = W_DATA;
                end
            end
            W_DATA: begin
                m_w      = bus.i_axi_s_w[wgrant_reg];
                m_wvalid = bus.i_axi_s_wvalid[wgrant_reg];
                if (m_wvalid && bus.i_axi_m_wready && m_w.last) begin
                    wstate_next = W_RESP;
                end
            end
            W_RESP: begin
                m_bready = bus.i_axi_s_bready[wgrant_reg];
                if (bus.i_axi_m_bvalid && m_bready) begin
                    wstate_next = W_IDLE;
                    wptr_next   = ptr_inc(wgrant_reg);
                end
            end
            default: wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_reg <= W_IDLE;
            wgrant_reg <= '0;
            wptr_reg   <= '0;
        end else begin
            wstate_reg <= wstate_next;
            wgrant_reg <= wgrant_next;
            wptr_reg   <= wptr_next;
        end
    end

    // ---------------- read path ----------------
    arb_rstate_e        rstate_reg, rstate_next;
    logic [GRANT_W-1:0] rgrant_reg, rgrant_next;
    logic [GRANT_W-1:0] rptr_reg, rptr_next;
    logic [GRANT_W-1:0] rwin;
    logic               rany;

    axi_ar_t m_ar;
    logic    m_arvalid;
    logic    m_rready;

    rr_pick_next #(.N(N_MANAGERS), .IDX_W(GRANT_W)) u_rpick (
        .valid     (arvalid_vec),
        .ptr       (rptr_reg),
        .any_valid (rany),
        .winner    (rwin)
    );

    always_comb begin
        rstate_next = rstate_reg;
        rgrant_next = rgrant_reg;
        rptr_next   = rptr_reg;
        m_ar        = '0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        case (rstate_reg)
            R_IDLE: begin
                if (rany) begin
                    rgrant_next = rwin;
                    rstate_next = R_AR;
                end
            end
            R_AR: begin
                m_ar      = bus.i_axi_s_ar[rgrant_reg];
                m_arvalid = bus.i_axi_s_arvalid[rgrant_reg];
                if (m_arvalid && bus.i_axi_m_arready) begin
                    rstate_next = R_DATA;
                end
            end
            R_DATA: begin
                m_rready = bus.i_axi_s_rready[rgrant_reg];
                if (bus.i_axi_m_rvalid && m_rready && bus.i_axi_m_r.last) begin
                    rstate_next = R_IDLE;
                    rptr_next   = ptr_inc(rgrant_reg);
                end
            end
            default: rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_reg <= R_IDLE;
            rgrant_reg <= '0;
            rptr_reg   <= '0;
        end else begin
            rstate_reg <= rstate_next;
            rgrant_reg <= rgrant_next;
            rptr_reg   <= rptr_next;
        end
    end

    // ---------------- downstream port ----------------
    assign bus.o_axi_m_aw      = m_aw;
    assign bus.o_axi_m_awvalid = m_awvalid;
    assign bus.o_axi_m_w       = m_w;
    assign bus.o_axi_m_wvalid  = m_wvalid;
    assign bus.o_axi_m_bready  = m_bready;
    assign bus.o_axi_m_ar      = m_ar;
    assign bus.o_axi_m_arvalid = m_arvalid;
    assign bus.o_axi_m_rready  = m_rready;

    // ---------------- upstream ports: only the granted index sees anything ----------------
    generate
        for (genvar gi = 0; gi < N_MANAGERS; gi++) begin : g_up
            logic wsel;
            logic rsel;
            assign wsel = (wgrant_reg == GRANT_W'(gi));
            assign rsel = (rgrant_reg == GRANT_W'(gi));

            assign bus.o_axi_s_awready[gi] = (wstate_reg == W_AW)   && wsel && bus.i_axi_m_awready;
            assign bus.o_axi_s_wready[gi]  = (wstate_reg == W_DATA) && wsel && bus.i_axi_m_wready;
            assign bus.o_axi_s_bvalid[gi]  = (wstate_reg == W_RESP) && wsel && bus.i_axi_m_bvalid;
            assign bus.o_axi_s_b[gi]       = ((wstate_reg == W_RESP) && wsel) ? bus.i_axi_m_b : '0;

            assign bus.o_axi_s_arready[gi] = (rstate_reg == R_AR)   && rsel && bus.i_axi_m_arready;
            assign bus.o_axi_s_rvalid[gi]  = (rstate_reg == R_DATA) && rsel && bus.i_axi_m_rvalid;
            assign bus.o_axi_s_r[gi]       = ((rstate_reg == R_DATA) && rsel) ? bus.i_axi_m_r : '0;
        end
    endgenerate

`ifdef AXI_ARB_ID_CHECK_EN
    // Compares response IDs with the granted request ID; routing is unaffected.
    logic [AXI_ID_W-1:0] awid_reg;
    logic [AXI_ID_W-1:0] arid_reg;
    logic                id_err_reg;
    logic                aw_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = (wstate_reg == W_AW)   && m_awvalid && bus.i_axi_m_awready;
    assign b_hs  = (wstate_reg == W_RESP) && bus.i_axi_m_bvalid && m_bready;
    assign ar_hs = (rstate_reg == R_AR)   && m_arvalid && bus.i_axi_m_arready;
    assign r_hs  = (rstate_reg == R_DATA) && bus.i_axi_m_rvalid && m_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            awid_reg   <= '0;
            arid_reg   <= '0;
            id_err_reg <= 1'b0;
        end else begin
            if (aw_hs) awid_reg <= m_aw.id;
            if (ar_hs) arid_reg <= m_ar.id;
            if (b_hs && (bus.i_axi_m_b.id != awid_reg)) begin
                id_err_reg <= 1'b1;
                $error("axi_rr_arbiter: B id mismatch mgr=%0d got=%0h expected=%0h",
                       wgrant_reg, bus.i_axi_m_b.id, awid_reg);
            end
            if (r_hs && (bus.i_axi_m_r.id != arid_reg)) begin
                id_err_reg <= 1'b1;
                $error("axi_rr_arbiter: R id mismatch mgr=%0d got=%0h expected=%0h",
                       rgrant_reg, bus.i_axi_m_r.id, arid_reg);
            end
        end
    end

    assign o_id_err = id_err_reg;
`endif

endmodule
